// File: rtl/wall_scroller.sv
// rtl/wall_scroller.sv - pulls wall heights, scrolls walls, detects bird hits, counts cleared walls
// Optional feature macro: SCROLL_SPEEDUP_EN (divisor shrinks every 8 walls cleared)
module wall_scroller #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int WALL_W     = 10,
  parameter int GAP_H      = 30,
  parameter int SCROLL_DIV = 2,
  parameter int BIRD_X     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [7:0] height_in,
  input  logic [7:0] bird_y,
  output logic       height_req,
  output logic [7:0] wall_x,
  output logic [7:0] gap_top,
  output logic       wall_active,
  output logic       collision,
  output logic [7:0] score
);

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL, HIT} state_t;

  localparam logic [7:0] X_SPAWN   = 8'(SCREEN_W - 1);
  localparam logic [7:0] GAP_MAX   = 8'(SCREEN_H - GAP_H);
  localparam logic [8:0] BIRD_X9   = 9'(BIRD_X);
  localparam logic [8:0] WALL_SPAN = 9'(WALL_W - 1);
  localparam logic [8:0] GAP_H9    = 9'(GAP_H);
  localparam logic [3:0] DIV_INIT  = 4'(SCROLL_DIV);

  state_t     state, state_nxt;
  logic [3:0] divider;
  logic [3:0] div_eff;
  logic       overlap, outside, hit, step, wall_done;
  logic [7:0] score_inc;

  // 9-bit compares so wall_x + WALL_W - 1 and gap_top + GAP_H cannot wrap
  always_comb begin
    overlap   = (BIRD_X9 >= {1'b0, wall_x}) && (BIRD_X9 <= ({1'b0, wall_x} + WALL_SPAN));
    outside   = ({1'b0, bird_y} < {1'b0, gap_top}) ||
                ({1'b0, bird_y} >= ({1'b0, gap_top} + GAP_H9));
    hit       = (state == SCROLL) && overlap && outside;
    step      = (state == SCROLL) && !hit && frame_tick && (divider == div_eff - 4'd1);
    wall_done = step && (wall_x == 8'd0);
    score_inc = (score == 8'hFF) ? 8'hFF : score + 8'd1;
  end

`ifdef SCROLL_SPEEDUP_EN
  // score_inc differs from score only on a real transition, and is then nonzero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_eff <= DIV_INIT;
    end else if ((state == HIT) && start) begin
      div_eff <= DIV_INIT;
    end else if (wall_done && (score != 8'hFF) && (score_inc[2:0] == 3'd0) && (div_eff > 4'd1)) begin
      div_eff <= div_eff - 4'd1;
    end
  end
`else
  assign div_eff = DIV_INIT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    height_req  = 1'b0;
    wall_active = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        height_req = 1'b1;
        state_nxt  = SCROLL;
      end
      SCROLL: begin
        wall_active = 1'b1;
        if (hit)            state_nxt = HIT;
        else if (wall_done) state_nxt = LOAD;
      end
      HIT: begin
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wall_x    <= X_SPAWN;
      gap_top   <= 8'd0;
      collision <= 1'b0;
      score     <= 8'd0;
      divider   <= 4'd0;
    end else begin
      case (state)
        LOAD: begin
          gap_top <= (height_in > GAP_MAX) ? GAP_MAX : height_in;
          wall_x  <= X_SPAWN;
          divider <= 4'd0;
        end
        SCROLL: begin
          // a hit freezes position and score even if a frame tick coincides
          if (hit) begin
            collision <= 1'b1;
          end else if (frame_tick) begin
            if (divider == div_eff - 4'd1) begin
              divider <= 4'd0;
              if (wall_x == 8'd0) score  <= score_inc;
              else                wall_x <= wall_x - 8'd1;
            end else begin
              divider <= divider + 4'd1;
            end
          end
        end
        HIT: begin
          if (start) begin
            collision <= 1'b0;
            score     <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_scroller.sv
// tb/tb_wall_scroller.sv - directed bench for wall_scroller with a tick-count based reference model
module tb_wall_scroller;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int WALL_W     = 10;
  localparam int GAP_H      = 30;
  localparam int SCROLL_DIV = 2;
  localparam int BIRD_X     = 20;

  localparam int S_IDLE = 0, S_LOAD = 1, S_SCROLL = 2, S_HIT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] height_in = 8'd0;
  logic [7:0] bird_y = 8'd60;
  logic       height_req;
  logic [7:0] wall_x;
  logic [7:0] gap_top;
  logic       wall_active;
  logic       collision;
  logic [7:0] score;

  int n_chk  = 0;
  int n_fail = 0;

  wall_scroller #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .WALL_W(WALL_W),
    .GAP_H(GAP_H), .SCROLL_DIV(SCROLL_DIV), .BIRD_X(BIRD_X)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .height_in(height_in), .bird_y(bird_y), .height_req(height_req),
    .wall_x(wall_x), .gap_top(gap_top), .wall_active(wall_active),
    .collision(collision), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: wall position derives from frame ticks counted since the wall spawned
  int m_state = S_IDLE;
  int m_wx    = SCREEN_W - 1;
  int m_gap   = 0;
  int m_coll  = 0;
  int m_score = 0;
  int m_ticks = 0;
  int m_div   = SCROLL_DIV;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = S_IDLE; m_wx = SCREEN_W - 1; m_gap = 0; m_coll = 0;
      m_score = 0; m_ticks = 0; m_div = SCROLL_DIV;
    end else begin
      case (m_state)
        S_IDLE: if (start) m_state = S_LOAD;
        S_LOAD: begin
          m_gap   = (int'(height_in) > SCREEN_H - GAP_H) ? SCREEN_H - GAP_H : int'(height_in);
          m_wx    = SCREEN_W - 1;
          m_ticks = 0;
          m_state = S_SCROLL;
        end
        S_SCROLL: begin
          if ((BIRD_X >= m_wx) && (BIRD_X <= m_wx + WALL_W - 1) &&
              ((int'(bird_y) < m_gap) || (int'(bird_y) >= m_gap + GAP_H))) begin
            m_coll  = 1;
            m_state = S_HIT;
          end else if (frame_tick) begin
            m_ticks++;
            if (m_ticks == SCREEN_W * m_div) begin
              int old_score = m_score;
              m_score = (m_score < 255) ? m_score + 1 : 255;
`ifdef SCROLL_SPEEDUP_EN
              if (m_score != old_score && m_score % 8 == 0 && m_div > 1) m_div--;
`else
              if (m_score == old_score) m_score = 255;
`endif
              m_state = S_LOAD;
            end else begin
              m_wx = SCREEN_W - 1 - m_ticks / m_div;
            end
          end
        end
        default: if (start) begin
          m_coll = 0; m_score = 0; m_div = SCROLL_DIV; m_state = S_LOAD;
        end
      endcase
    end
  end

  logic prev_req = 1'b0;
  always @(negedge clk) begin
    chk("height_req", int'(height_req), int'(m_state == S_LOAD));
    chk("wall_active", int'(wall_active), int'(m_state == S_SCROLL));
    chk("wall_x", int'(wall_x), m_wx);
    chk("gap_top", int'(gap_top), m_gap);
    chk("collision", int'(collision), m_coll);
    chk("score", int'(score), m_score);
    chk("req_back_to_back", int'(height_req && prev_req), 0);
    prev_req <= height_req;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_edge();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_edge();
      cyc();
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_wall_x", int'(wall_x), 159);
    chk("rst_gap", int'(gap_top), 0);
    chk("rst_active", int'(wall_active), 0);
    chk("rst_score", int'(score), 0);
    ticks(3);
    chk("idle_hold_wall_x", int'(wall_x), 159);

    height_in = 8'd50; bird_y = 8'd60; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("load_req", int'(height_req), 1);
    cyc();
    chk("first_gap", int'(gap_top), 50);
    chk("first_wall_x", int'(wall_x), 159);
    chk("first_active", int'(wall_active), 1);
    chk("first_req_low", int'(height_req), 0);

    ticks(4);
    chk("four_ticks_wall_x", int'(wall_x), 157);
    ticks(315);
    tick_edge();
    chk("end_req", int'(height_req), 1);
    chk("end_score", int'(score), 1);
    chk("end_wall_x", int'(wall_x), 0);
    cyc();
    chk("respawn_wall_x", int'(wall_x), 159);

    ticks(278);
    chk("at20_wall_x", int'(wall_x), 20);
    ticks(10);
    chk("at15_wall_x", int'(wall_x), 15);
    chk("at15_no_hit", int'(collision), 0);
    bird_y = 8'd45;
    cyc();
    chk("hit_flag", int'(collision), 1);
    chk("hit_active", int'(wall_active), 0);
    ticks(4);
    chk("hit_frozen_x", int'(wall_x), 15);
    chk("hit_frozen_score", int'(score), 1);

    height_in = 8'd100; bird_y = 8'd100; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_req", int'(height_req), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_coll", int'(collision), 0);
    cyc();
    chk("clamp_gap", int'(gap_top), 90);

    ticks(279);
    chk("tie_pre_x", int'(wall_x), 20);
    frame_tick = 1'b1; bird_y = 8'd10;
    cyc();
    frame_tick = 1'b0;
    chk("tie_coll", int'(collision), 1);
    chk("tie_wall_x", int'(wall_x), 20);

    height_in = 8'd0; bird_y = 8'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("zero_gap", int'(gap_top), 0);
    ticks(960);
    ticks(158);
    chk("mid_wall_x", int'(wall_x), 80);
    chk("mid_score", int'(score), 3);
    #1 reset = 1'b1;
    #1;
    chk("async_wall_x", int'(wall_x), 159);
    chk("async_score", int'(score), 0);
    chk("async_active", int'(wall_active), 0);
    chk("async_gap", int'(gap_top), 0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();

`ifdef SCROLL_SPEEDUP_EN
    height_in = 8'd0; bird_y = 8'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    ticks(8 * 320);
    chk("speed_score", int'(score), 8);
    ticks(1);
    chk("speed_one_tick", int'(wall_x), 158);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
